qc_ldpc_info_loader: RTL and testbench

QC_LDPC_INFO_LOADER -- requirements
Module: qc_ldpc_info_loader

---
 rtl/qc_ldpc_info_loader.sv | 148 ++++++++++++++
 tb/tb_qc_ldpc_info_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qc_ldpc_info_loader.sv
// Collects one code block of info words, zero-pads each to the frame's Z and replays them to the encoder.
// Optional invalid-Z detection (err_z) is compiled only when QC_LDPC_LOADER_ZCHK_EN is defined.
module qc_ldpc_info_loader #(
    parameter int HIGHEST_SUPPORTED_Z_VAL    = 81,
    parameter int NUM_INFO_BLKS_PER_CODE_BLK = 20,
    parameter int NUM_OF_SUPPORTED_Z         = 3,
    parameter int Z_VALUE_ARRAY [NUM_OF_SUPPORTED_Z] = '{27, 54, 81}
) (
    input  logic                                          CLK,
    input  logic                                          rst,
    input  logic [NUM_OF_SUPPORTED_Z-1:0]                 req_z,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [HIGHEST_SUPPORTED_Z_VAL-1:0]            s_data,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [HIGHEST_SUPPORTED_Z_VAL-1:0]            m_data,
    output logic [$clog2(NUM_INFO_BLKS_PER_CODE_BLK)-1:0] m_idx,
    output logic [NUM_OF_SUPPORTED_Z-1:0]                 m_zsel,
    output logic                                          m_first,
    output logic                                          m_last,
    output logic                                          err_z
);
    localparam int MAXZ  = HIGHEST_SUPPORTED_Z_VAL;
    localparam int NIB   = NUM_INFO_BLKS_PER_CODE_BLK;
    localparam int NZ    = NUM_OF_SUPPORTED_Z;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  wcnt_q, wcnt_d;
    logic [IDX_W-1:0]  rcnt_q, rcnt_d;
    logic [NZ-1:0]     zsel_q, zsel_d;
    logic [MAXZ-1:0]   buf_q [NIB];
    logic [NZ-1:0]     sel_z;
    logic [MAXZ-1:0]   wr_data;
    logic              wr_en;
    logic              accept;
    logic              first_accept;

    function automatic logic is_onehot(input logic [NZ-1:0] sel);
        int ones;
        ones = 0;
        for (int k = 0; k < NZ; k++) begin
            if (sel[k]) ones++;
        end
        return (ones == 1);
    endfunction

    // Keeps bits [Z-1:0] for the selected Z; an invalid select clears the whole word.
    function automatic logic [MAXZ-1:0] pad_mask(input logic [NZ-1:0] sel);
        logic [MAXZ-1:0] m;
        m = '0;
        for (int k = 0; k < NZ; k++) begin
            if (sel[k]) begin
                for (int b = 0; b < MAXZ; b++) begin
                    if (b < Z_VALUE_ARRAY[k]) m[b] = 1'b1;
                end
            end
        end
        return is_onehot(sel) ? m : '0;
    endfunction

    assign s_ready      = !rst && (state_q != DRAIN);
    assign accept       = s_valid && s_ready;
    assign first_accept = accept && (state_q == IDLE);

    // Word 0 is padded with the live req_z; later words use the latched copy so mid-frame changes are ignored.
    assign sel_z   = (state_q == IDLE) ? req_z : zsel_q;
    assign wr_data = s_data & pad_mask(sel_z);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        zsel_d  = zsel_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (state_q == IDLE) zsel_d = req_z;
                    if (wcnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                        wcnt_d  = '0;
                    end else begin
                        state_d = FILL;
                        wcnt_d  = wcnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (rcnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            zsel_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            zsel_q  <= zsel_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) buf_q[wcnt_q] <= wr_data;
    end

    // Outputs are forced inactive combinationally while rst is high, not just after the edge.
    assign m_valid = !rst && (state_q == DRAIN);
    assign m_data  = m_valid ? buf_q[rcnt_q] : '0;
    assign m_idx   = rst ? '0 : rcnt_q;
    assign m_zsel  = rst ? '0 : zsel_q;
    assign m_first = m_valid && (rcnt_q == '0);
    assign m_last  = m_valid && (rcnt_q == LAST_IDX);

`ifdef QC_LDPC_LOADER_ZCHK_EN
    logic err_q;

    always_ff @(posedge CLK) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= first_accept && !is_onehot(req_z);
    end

    assign err_z = err_q && !rst;
`else
    assign err_z = 1'b0;
`endif

endmodule

// File: tb/tb_qc_ldpc_info_loader.sv
// Randomized bench for qc_ldpc_info_loader: a frame-level queue model checked every cycle, plus literal pins.
module tb_qc_ldpc_info_loader;
    localparam int MAXZ = 81;
    localparam int NIB  = 20;
`ifdef QC_LDPC_LOADER_ZCHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req_z = 3'b001;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [MAXZ-1:0] s_data = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [MAXZ-1:0] m_data;
    logic [4:0]      m_idx;
    logic [2:0]      m_zsel;
    logic            m_first;
    logic            m_last;
    logic            err_z;

    always #5 clk = ~clk;

    qc_ldpc_info_loader dut (
        .CLK(clk), .rst(rst), .req_z(req_z),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_idx(m_idx), .m_zsel(m_zsel), .m_first(m_first), .m_last(m_last),
        .err_z(err_z)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int out_cnt = 0;
    int mv_cnt = 0;
    int err_cnt = 0;
    int stall_seen = 0;
    int stall_n = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int zarr [3] = '{27, 54, 81};

    function automatic logic [MAXZ-1:0] pad(input logic [MAXZ-1:0] d, input logic [2:0] z);
        logic [MAXZ:0] one;
        logic [MAXZ:0] mask;
        int zv;
        one = 1;
        zv = 0;
        if ($countones(z) != 1) return '0;
        for (int k = 0; k < 3; k++) if (z[k]) zv = zarr[k];
        mask = (one << zv) - 1;
        return d & mask[MAXZ-1:0];
    endfunction

    function automatic logic [MAXZ-1:0] rnd();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[MAXZ-1:0];
    endfunction

    // ---------------- scoreboard model ----------------
    logic [MAXZ-1:0] frame_q[$];
    logic [MAXZ-1:0] exp_q[$];
    logic [2:0]      frame_zsel = '0;
    logic            err_pend = 1'b0;

    always @(negedge clk) begin : cmp
        logic exp_sr, exp_mv, exp_err;
        int idx;
        exp_sr = !rst && (exp_q.size() == 0);
        exp_mv = !rst && (exp_q.size() != 0);
        exp_err = ZCHK && err_pend && !rst;
        err_pend = 1'b0;
        check("s_ready", s_ready, exp_sr);
        check("m_valid", m_valid, exp_mv);
        check("err_z", err_z, exp_err);
        if (err_z) err_cnt++;
        if (m_valid) mv_cnt++;
        if (rst) begin
            check("rst_m_idx", m_idx, 0);
            check("rst_m_zsel", m_zsel, 0);
            check("rst_m_first", m_first, 0);
            check("rst_m_last", m_last, 0);
            frame_q.delete();
            exp_q.delete();
        end else begin
            if (exp_mv) begin
                idx = NIB - exp_q.size();
                check("m_data", m_data, exp_q[0]);
                check("m_idx", m_idx, 128'(idx));
                check("m_first", m_first, idx == 0);
                check("m_last", m_last, idx == NIB - 1);
                check("m_zsel", m_zsel, frame_zsel);
                if (!m_ready && idx == 7) stall_seen++;
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    out_cnt++;
                end
            end
            if (s_valid && exp_sr) begin
                if (frame_q.size() == 0) begin
                    frame_zsel = req_z;
                    err_pend = ($countones(req_z) != 1);
                end
                frame_q.push_back(pad(s_data, frame_zsel));
                if (frame_q.size() == NIB) begin
                    exp_q = frame_q;
                    frame_q.delete();
                end
            end
        end
    end

    // ---------------- m_ready driver ----------------
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                if (m_valid && m_idx == 5'd7 && stall_n < 5) begin
                    m_ready = 1'b0;
                    stall_n++;
                end else begin
                    m_ready = 1'b1;
                end
            end
        endcase
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_word(input logic [MAXZ-1:0] d, input logic [2:0] z);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        req_z = z;
        do begin
            @(negedge clk);
            acc = s_ready;
            n++;
            @(posedge clk);
            #1;
        end while (!acc && n < 200);
        if (!acc) check("accept_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || frame_q.size() != 0) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // all-ones, Z=27, back-to-back, always ready
        ready_mode = 0;
        base = out_cnt;
        for (int i = 0; i < NIB; i++) send_word('1, 3'b001);
        @(negedge clk);
        check("t1_latency_valid", m_valid, 1);
        check("t1_first_data", m_data, 128'h7FFFFFF);
        check("t1_first_idx", m_idx, 0);
        check("t1_first_flag", m_first, 1);
        check("t1_first_zsel", m_zsel, 3'b001);
        wait_drain();
        check("t1_count", out_cnt - base, NIB);

        // Z=81, s_valid toggling, random ready
        ready_mode = 1;
        base = out_cnt;
        for (int i = 0; i < NIB; i++) begin
            send_word(rnd(), 3'b100);
            s_data = rnd();
            @(posedge clk);
            #1;
        end
        wait_drain();
        check("t2_count", out_cnt - base, NIB);

        // stall of 5 cycles at idx 7
        ready_mode = 2;
        stall_n = 0;
        stall_seen = 0;
        for (int i = 0; i < NIB; i++) send_word(rnd(), 3'b010);
        wait_drain();
        check("t3_stall_cycles", stall_seen, 5);

        // req_z changes after word 3; frame stays at Z=54
        ready_mode = 0;
        for (int i = 0; i < NIB; i++) send_word('1, (i < 4) ? 3'b010 : 3'b001);
        @(negedge clk);
        check("t4_first_data", m_data, 128'h3FFFFFFFFFFFFF);
        check("t4_zsel", m_zsel, 3'b010);
        wait_drain();

        // reset mid-fill, then a full frame
        ready_mode = 1;
        for (int i = 0; i < 10; i++) send_word(rnd(), 3'b100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = mv_cnt;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("t5_no_valid", mv_cnt - base, 0);
        base = out_cnt;
        for (int i = 0; i < NIB; i++) send_word(rnd(), 3'b001);
        wait_drain();
        check("t5_count", out_cnt - base, NIB);

        // invalid Z: all-zero frame, err_z pulse only with the check compiled in
        ready_mode = 0;
        base = err_cnt;
        for (int i = 0; i < NIB; i++) send_word('1, 3'b011);
        @(negedge clk);
        check("t6_first_data", m_data, 0);
        check("t6_zsel", m_zsel, 3'b011);
        wait_drain();
        check("t6_err_pulses", err_cnt - base, ZCHK ? 1 : 0);

        // random frames with random valid gaps and random Z choices
        ready_mode = 1;
        for (int f = 0; f < 3; f++) begin
            logic [2:0] z;
            z = 3'(1 << $urandom_range(0, 2));
            for (int i = 0; i < NIB; i++) begin
                send_word(rnd(), z);
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                end
            end
            wait_drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
